crossbar_sched4x4: RTL and testbench

Upstream scheduler for the 4x4 crossbar datapath. It takes per-input destination requests, runs an independent round-robin arbiter for each output, and holds each granted connection for a fixed number of cycles. It drives the crossbar's 16-bit control word registered, so the datapath sees stable selects for the whole connection.

---
 rtl/crossbar_pkg.sv | 8 +
 rtl/rr_arbiter4.sv | 23 ++
 rtl/crossbar_sched4x4.sv | 90 +++++++++
 tb/tb_crossbar_sched4x4.sv | 121 ++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared constants and types for the 4x4 crossbar scheduler
package crossbar_pkg;
  localparam int N_PORTS = 4;
  localparam int SEL_W = 2;
  localparam int SEL_LSB = 0;
  localparam int EN_LSB = 8;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick starting at ptr
// req: request bits; ptr: search start; gnt: one-hot winner; idx: winner index; any: a winner exists
module rr_arbiter4
  import crossbar_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  sel_t               ptr,
  output logic [N_PORTS-1:0] gnt,
  output sel_t               idx,
  output logic               any
);
  always_comb begin
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    for (int o = 0; o < N_PORTS; o++)
      if (!any && req[ptr + sel_t'(o)]) begin
        any = 1'b1;
        idx = ptr + sel_t'(o);
        gnt[ptr + sel_t'(o)] = 1'b1;
      end
  end
endmodule

// File: rtl/crossbar_sched4x4.sv
// crossbar_sched4x4: per-output round-robin scheduler driving a registered 4x4 crossbar control word
// clk/rst_n: clock and async active-low reset; req_valid/req_dst: per-input destination requests;
// abort: clears all connections; gnt: one-cycle accept pulse per input;
// xbar_ctrl: {4'b0, enables[11:8], selects[7:0]}; out_busy: per-output connection active
module crossbar_sched4x4
  import crossbar_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [7:0]  req_dst,
  input  logic        abort,
  output logic [3:0]  gnt,
  output logic [15:0] xbar_ctrl,
  output logic [3:0]  out_busy
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);
  logic [CNT_W-1:0]   cnt_q [N_PORTS];
  logic [CNT_W-1:0]   cnt_d [N_PORTS];
  sel_t               sel_q [N_PORTS];
  sel_t               sel_d [N_PORTS];
  sel_t               ptr_q [N_PORTS];
  sel_t               ptr_d [N_PORTS];
  logic [N_PORTS-1:0] gnt_q, gnt_d, busy_q, busy_d;
  logic [N_PORTS-1:0] cand [N_PORTS];
  logic [N_PORTS-1:0] arb_gnt [N_PORTS];
  sel_t               arb_idx [N_PORTS];
  logic [N_PORTS-1:0] arb_any;
  // An output may re-arbitrate on its last hold cycle so connections run back to back;
  // inputs granted last cycle are masked because their request may still be up.
  always_comb begin
    cand = '{default: '0};
    for (int k = 0; k < N_PORTS; k++)
      for (int i = 0; i < N_PORTS; i++)
        cand[k][i] = req_valid[i] && (req_dst[SEL_W*i +: SEL_W] == sel_t'(k)) && !gnt_q[i]
                     && (cnt_q[k] <= CNT_W'(1)) && !abort;
  end
  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    rr_arbiter4 u_arb (
      .req(cand[g]),
      .ptr(ptr_q[g]),
      .gnt(arb_gnt[g]),
      .idx(arb_idx[g]),
      .any(arb_any[g])
    );
  end
  always_comb begin
    gnt_d = '0;
    busy_d = '0;
    cnt_d = cnt_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    for (int k = 0; k < N_PORTS; k++) begin
      gnt_d = gnt_d | arb_gnt[k];
      cnt_d[k] = abort ? '0 : arb_any[k] ? HOLD_V : (cnt_q[k] != '0) ? cnt_q[k] - CNT_W'(1) : cnt_q[k];
      sel_d[k] = arb_any[k] ? arb_idx[k] : sel_q[k];
      ptr_d[k] = arb_any[k] ? arb_idx[k] + sel_t'(1) : ptr_q[k];
      busy_d[k] = cnt_d[k] != '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      busy_q <= '0;
      for (int k = 0; k < N_PORTS; k++) begin
        cnt_q[k] <= '0;
        sel_q[k] <= '0;
        ptr_q[k] <= '0;
      end
    end else begin
      gnt_q <= gnt_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    xbar_ctrl = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      xbar_ctrl[SEL_LSB + SEL_W*k +: SEL_W] = sel_q[k];
      xbar_ctrl[EN_LSB + k] = busy_q[k];
    end
  end
  assign gnt = gnt_q;
  assign out_busy = busy_q;
endmodule

// File: tb/tb_crossbar_sched4x4.sv
// tb_crossbar_sched4x4: directed checks of the crossbar scheduler with HOLD_CYCLES=4 and HOLD_CYCLES=1
module tb_crossbar_sched4x4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        abort = 1'b0;
  logic [3:0]  req_valid_a = '0, req_valid_b = '0;
  logic [7:0]  req_dst_a = '0, req_dst_b = '0;
  logic [3:0]  gnt_a, gnt_b, busy_a, busy_b;
  logic [15:0] xbar_a, xbar_b;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] seq_gnt [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [1:0] seq_idx [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
  crossbar_sched4x4 #(.HOLD_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_dst(req_dst_a), .abort(abort),
    .gnt(gnt_a), .xbar_ctrl(xbar_a), .out_busy(busy_a)
  );
  crossbar_sched4x4 #(.HOLD_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_dst(req_dst_b), .abort(abort),
    .gnt(gnt_b), .xbar_ctrl(xbar_b), .out_busy(busy_b)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    req_valid_a = 4'($urandom);
    req_dst_a = 8'($urandom);
    req_valid_b = 4'($urandom);
    req_dst_b = 8'($urandom);
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_gnt_a", {12'b0, gnt_a}, 16'h0);
    chk("rst_xbar_a", xbar_a, 16'h0);
    chk("rst_busy_a", {12'b0, busy_a}, 16'h0);
    chk("rst_gnt_b", {12'b0, gnt_b}, 16'h0);
    chk("rst_xbar_b", xbar_b, 16'h0);
    req_valid_a = 4'b0100;
    req_dst_a = 8'h10;
    req_valid_b = '0;
    req_dst_b = '0;
    rst_n = 1'b1;
    step();
    chk("single_gnt", {12'b0, gnt_a}, 16'h0004);
    chk("single_xbar", xbar_a, 16'h0208);
    chk("single_busy", {12'b0, busy_a}, 16'h0002);
    req_valid_a = '0;
    step();
    chk("single_gnt_pulse", {12'b0, gnt_a}, 16'h0);
    chk("single_busy_t2", {12'b0, busy_a}, 16'h0002);
    step();
    step();
    chk("single_busy_t4", {12'b0, busy_a}, 16'h0002);
    step();
    chk("single_idle_t5", {12'b0, busy_a}, 16'h0);
    chk("single_sel_kept", xbar_a, 16'h0008);
    req_valid_a = 4'b1011;
    req_dst_a = 8'h00;
    for (int j = 0; j < 16; j++) begin
      step();
      chk($sformatf("rr_gnt_%0d", j), {12'b0, gnt_a}, (j % 4 == 0) ? {12'b0, seq_gnt[j/4]} : 16'h0);
      chk($sformatf("rr_en0_%0d", j), {15'b0, xbar_a[8]}, 16'h1);
      if (j % 4 == 0) chk($sformatf("rr_sel0_%0d", j), {14'b0, xbar_a[1:0]}, {14'b0, seq_idx[j/4]});
    end
    req_valid_a = '0;
    step();
    chk("rr_expire", {12'b0, busy_a}, 16'h0);
    req_valid_a = 4'b1111;
    req_dst_a = 8'h1B;
    step();
    chk("perm_gnt", {12'b0, gnt_a}, 16'h000F);
    chk("perm_xbar", xbar_a, 16'h0F1B);
    req_valid_a = '0;
    step();
    chk("perm_busy_cnt3", {12'b0, busy_a}, 16'h000F);
    abort = 1'b1;
    req_valid_a = 4'b0001;
    req_dst_a = 8'h02;
    step();
    chk("abort_busy", {12'b0, busy_a}, 16'h0);
    chk("abort_gnt", {12'b0, gnt_a}, 16'h0);
    chk("abort_xbar", xbar_a, 16'h001B);
    abort = 1'b0;
    step();
    chk("post_abort_gnt", {12'b0, gnt_a}, 16'h0001);
    chk("post_abort_xbar", xbar_a, 16'h040B);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", {12'b0, gnt_a}, 16'h0);
    chk("async_rst_xbar", xbar_a, 16'h0);
    chk("async_rst_busy", {12'b0, busy_a}, 16'h0);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_gnt", {12'b0, gnt_a}, 16'h0001);
    chk("post_rst_xbar", xbar_a, 16'h0400);
    req_valid_a = '0;
    req_valid_b = 4'b0011;
    req_dst_b = 8'h0A;
    for (int j = 0; j < 8; j++) begin
      step();
      chk($sformatf("h1_gnt_%0d", j), {12'b0, gnt_b}, (j % 2 == 0) ? 16'h0001 : 16'h0002);
      chk($sformatf("h1_busy_%0d", j), {12'b0, busy_b}, 16'h0004);
      chk($sformatf("h1_sel_%0d", j), {14'b0, xbar_b[5:4]}, (j % 2 == 0) ? 16'h0 : 16'h1);
    end
    req_valid_b = '0;
    step();
    chk("h1_expire", {12'b0, busy_b}, 16'h0);
    chk("h1_gnt_idle", {12'b0, gnt_b}, 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
